// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexed common-anode 7-segment scanner with blank interval,
//            per-digit dp/enable and frame-synchronous load/ack updates.
//            Optional: LEADING_ZERO_BLANK_EN darkens leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_done,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_idx_last = IW'(DIGITS - 1);

  typedef enum logic [0:0] {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [4*DIGITS-1:0]  r_disp_data;
  logic [DIGITS-1:0]    r_disp_dp;
  logic [4*DIGITS-1:0]  r_shadow_data;
  logic [DIGITS-1:0]    r_shadow_dp;
  logic                 r_pending;
  logic                 r_ack_pend;

  phase_t               w_phase;
  logic                 w_commit;
  logic [3:0]           w_nib [DIGITS];
  logic [DIGITS-1:0]    w_lz_dark;
  logic [3:0]           w_cur_nib;
  logic                 w_cur_dp;
  logic                 w_cur_en;
  logic                 w_cur_dark;
  logic [DIGITS-1:0]    w_an_sel;
  logic [7:0]           w_seg_nxt;
  logic [DIGITS-1:0]    w_an_nxt;

  function automatic logic [6:0] hex_patt(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  assign w_commit = (r_cnt == c_cnt_last) && (r_idx == c_idx_last);

  generate
    if (BLANK_CYC > 0) begin : g_blank
      localparam logic [CW-1:0] c_blank = CW'(BLANK_CYC);
      assign w_phase = (r_cnt < c_blank) ? PH_BLANK : PH_SHOW;
    end else begin : g_noblank
      assign w_phase = PH_SHOW;
    end
  endgenerate

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
      assign w_nib[k] = r_disp_data[4*k +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // w_upper_zero[k]: nibble k and every nibble above it are zero
  logic [DIGITS-1:0] w_upper_zero;
  localparam logic [DIGITS-1:0] c_lz_mask = ~DIGITS'(1);

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
      if (k == DIGITS - 1) begin : g_top
        assign w_upper_zero[k] = (w_nib[k] == 4'h0);
      end else begin : g_chain
        assign w_upper_zero[k] = (w_nib[k] == 4'h0) && w_upper_zero[k+1];
      end
    end
  endgenerate

  assign w_lz_dark = w_upper_zero & ~r_disp_dp & c_lz_mask;
`else
  assign w_lz_dark = '0;
`endif

  generate
    if (DIGITS == 1) begin : g_sel_one
      assign w_cur_nib  = w_nib[0];
      assign w_cur_dp   = r_disp_dp[0];
      assign w_cur_en   = digit_en[0];
      assign w_cur_dark = w_lz_dark[0];
      assign w_an_sel   = '0;
    end else begin : g_sel_multi
      assign w_cur_nib  = w_nib[r_idx];
      assign w_cur_dp   = r_disp_dp[r_idx];
      assign w_cur_en   = digit_en[r_idx];
      assign w_cur_dark = w_lz_dark[r_idx];
      assign w_an_sel   = ~(DIGITS'(1) << r_idx);
    end
  endgenerate

  always_comb begin
    w_seg_nxt = 8'hFF;
    w_an_nxt  = '1;
    if (w_phase == PH_SHOW && !w_cur_dark) begin
      w_seg_nxt = {~w_cur_dp, hex_patt(w_cur_nib)};
      w_an_nxt  = w_cur_en ? w_an_sel : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
      r_ack_pend    <= 1'b0;
      load_ack      <= 1'b0;
      frame_done    <= 1'b0;
      SEG           <= 8'hFF;
      AN            <= '1;
    end else begin
      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A load on the commit cycle bypasses the shadow register entirely
      if (w_commit) begin
        if (load) begin
          r_disp_data <= data_in;
          r_disp_dp   <= dp_in;
        end else if (r_pending) begin
          r_disp_data <= r_shadow_data;
          r_disp_dp   <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow_data <= data_in;
        r_shadow_dp   <= dp_in;
        r_pending     <= 1'b1;
      end

      // ack lands with the first output of the new frame, one cycle after frame_done
      r_ack_pend <= w_commit && (load || r_pending);
      load_ack   <= r_ack_pend;
      frame_done <= w_commit;
      SEG        <= w_seg_nxt;
      AN         <= w_an_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed plus randomized check of seg_scan_ctrl against a
//            cycle-time arithmetic reference model (DIGITS=4, SCAN_DIV=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        load_ack;
  logic        frame_done;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .SEG        (SEG),
    .AN         (AN)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  // model: t = cycles since reset release; frame position is t mod FRAME
  int          t;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  bit          m_pend, m_took;

  function automatic logic [6:0] patt(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic step();
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_ack, e_fd;
    int         pos, slot, dig;
    bit         dark;
    @(posedge clk);
    e_seg = 8'hFF;
    e_an  = 4'hF;
    e_ack = 1'b0;
    e_fd  = 1'b0;
    if (!rst_n) begin
      t = 0; m_disp = '0; m_shadow = '0; m_dp = '0; m_sdp = '0;
      m_pend = 0; m_took = 0;
    end else begin
      pos  = t % FRAME;
      slot = pos % SCAN_DIV;
      dig  = pos / SCAN_DIV;
      e_fd  = (pos == FRAME - 1);
      e_ack = (pos == 0) && m_took;
      if (slot >= BLANK_CYC) begin
        dark = 0;
`ifdef LEADING_ZERO_BLANK_EN
        dark = (dig > 0) && ((m_disp >> (4 * dig)) == 16'h0) && !m_dp[dig];
`endif
        if (!dark) begin
          e_seg = {~m_dp[dig], patt(4'((m_disp >> (4 * dig)) & 16'hF))};
          e_an  = digit_en[dig] ? ~(4'b0001 << dig) : 4'hF;
        end
      end
      if (pos == FRAME - 1) begin
        m_took = load || m_pend;
        if (load) begin
          m_disp = data_in; m_dp = dp_in;
        end else if (m_pend) begin
          m_disp = m_shadow; m_dp = m_sdp;
        end
        m_pend = 0;
      end else if (load) begin
        m_shadow = data_in; m_sdp = dp_in; m_pend = 1;
      end
      t++;
    end
    @(negedge clk);
    n_tests += 4;
    assert (SEG === e_seg) else begin
      n_fail++; $error("FAIL seg t=%0d got=%h exp=%h", t, SEG, e_seg);
    end
    assert (AN === e_an) else begin
      n_fail++; $error("FAIL an t=%0d got=%h exp=%h", t, AN, e_an);
    end
    assert (load_ack === e_ack) else begin
      n_fail++; $error("FAIL load_ack t=%0d got=%b exp=%b", t, load_ack, e_ack);
    end
    assert (frame_done === e_fd) else begin
      n_fail++; $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_fd);
    end
  endtask

  task automatic do_load(input logic [15:0] d);
    data_in = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic goto_pos(input int p);
    while ((t % FRAME) != p) step();
  endtask

  logic [15:0] masks [4];

  initial begin
    masks    = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
    t        = 0;
    rst_n    = 1'b0;
    load     = 1'b1;
    data_in  = 16'hBEEF;
    dp_in    = 4'hF;
    digit_en = 4'hF;
    repeat (3) step();
    rst_n = 1'b1;
    load  = 1'b0;
    repeat (40) step();

    dp_in = 4'h0;
    do_load(16'h1234);
    repeat (80) step();

    goto_pos(16);
    do_load(16'hAAAA);
    repeat (48) step();

    goto_pos(4);
    do_load(16'h5555);
    repeat (3) step();
    do_load(16'h6666);
    repeat (40) step();

    goto_pos(FRAME - 1);
    do_load(16'h7777);
    repeat (40) step();

    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    do_load(16'h0008);
    repeat (70) step();

    digit_en = 4'hF;
    dp_in    = 4'h0;
    do_load(16'h0070);
    repeat (70) step();

    goto_pos(10);
    do_load(16'hC3C3);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (70) step();

    for (int i = 0; i < 2000; i++) begin
      load    = ($urandom_range(0, 11) == 0);
      data_in = 16'($urandom) & masks[$urandom_range(0, 3)];
      dp_in   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
      rst_n   = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    load  = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
